// File: rtl/button_debounce.sv
// Push-button conditioner: polarity fix, 2-FF synchronizer, debounce FSM with
// press/release/long-press strobes. All outputs are registered.
module button_debounce #(
  parameter int clk_f          = 25000000,
  parameter int t_debounce_ms  = 20,
  parameter int t_long_ms      = 1000,
  parameter bit btn_active_low = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);

  localparam int DB_CYCLES   = clk_f / 1000 * t_debounce_ms;
  localparam int LONG_CYCLES = clk_f / 1000 * t_long_ms;
  localparam int DB_W        = $clog2(DB_CYCLES + 1);
  localparam int LONG_W      = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_TERM   = DB_W'(DB_CYCLES);
  localparam logic [LONG_W-1:0] LONG_TERM = LONG_W'(LONG_CYCLES);

  generate
    if (DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_timing
      $error("button_debounce: need DB_CYCLES >= 1 and LONG_CYCLES > DB_CYCLES");
    end
  endgenerate

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT = 3'd1;
  localparam logic [2:0] ST_HELD       = 3'd2;
  localparam logic [2:0] ST_LONG       = 3'd3;
  localparam logic [2:0] ST_REL_WAIT   = 3'd4;

  logic              sync1_reg, sync2_reg;
  logic [2:0]        state_reg, state_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next, db_inc;
  logic [LONG_W-1:0] long_cnt_reg, long_cnt_next, long_inc;
  logic              ret_long_reg, ret_long_next;
  logic              pressed_reg, pressed_next;
  logic              long_held_reg, long_held_next;
  logic              press_pulse_reg, press_pulse_next;
  logic              release_pulse_reg, release_pulse_next;
  logic              long_pulse_reg, long_pulse_next;
  logic              do_press, start_release, do_release;
  logic              s;

  assign s = sync2_reg;

  // Saturating increments; the FSM leaves each wait state before the terminal value.
  assign db_inc   = (db_cnt_reg == DB_TERM) ? db_cnt_reg : db_cnt_reg + DB_W'(1);
  assign long_inc = (long_cnt_reg == LONG_TERM) ? long_cnt_reg : long_cnt_reg + LONG_W'(1);

  always_comb begin
    state_next         = state_reg;
    db_cnt_next        = db_cnt_reg;
    long_cnt_next      = long_cnt_reg;
    ret_long_next      = ret_long_reg;
    pressed_next       = pressed_reg;
    long_held_next     = long_held_reg;
    press_pulse_next   = 1'b0;
    release_pulse_next = 1'b0;
    long_pulse_next    = 1'b0;
    do_press           = 1'b0;
    start_release      = 1'b0;
    do_release         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        db_cnt_next = '0;
        if (s) begin
          if (DB_TERM == DB_W'(1)) begin
            do_press = 1'b1;
          end else begin
            state_next  = ST_PRESS_WAIT;
            db_cnt_next = DB_W'(1);
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_next  = ST_IDLE;
          db_cnt_next = '0;
        end else if (db_inc == DB_TERM) begin
          do_press = 1'b1;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      ST_HELD: begin
        if (!s) begin
          start_release = 1'b1;
          ret_long_next = 1'b0;
        end else begin
          long_cnt_next = long_inc;
          if (long_inc == LONG_TERM) begin
            long_pulse_next = 1'b1;
            long_held_next  = 1'b1;
            state_next      = ST_LONG;
          end
        end
      end
      ST_LONG: begin
        if (!s) begin
          start_release = 1'b1;
          ret_long_next = 1'b1;
        end
      end
      ST_REL_WAIT: begin
        if (s) begin
          // Bounce during release: resume where we were, long_cnt untouched.
          db_cnt_next = '0;
          state_next  = ret_long_reg ? ST_LONG : ST_HELD;
        end else if (db_inc == DB_TERM) begin
          do_release = 1'b1;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        db_cnt_next = '0;
      end
    endcase

    if (start_release) begin
      if (DB_TERM == DB_W'(1)) begin
        do_release = 1'b1;
      end else begin
        state_next  = ST_REL_WAIT;
        db_cnt_next = DB_W'(1);
      end
    end

    if (do_press) begin
      press_pulse_next = 1'b1;
      pressed_next     = 1'b1;
      long_cnt_next    = '0;
      db_cnt_next      = '0;
      state_next       = ST_HELD;
    end

    if (do_release) begin
      release_pulse_next = 1'b1;
      pressed_next       = 1'b0;
      long_held_next     = 1'b0;
      db_cnt_next        = '0;
      state_next         = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg         <= 1'b0;
      sync2_reg         <= 1'b0;
      state_reg         <= ST_IDLE;
      db_cnt_reg        <= '0;
      long_cnt_reg      <= '0;
      ret_long_reg      <= 1'b0;
      pressed_reg       <= 1'b0;
      long_held_reg     <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      long_pulse_reg    <= 1'b0;
    end else begin
      sync1_reg         <= button ^ btn_active_low;
      sync2_reg         <= sync1_reg;
      state_reg         <= state_next;
      db_cnt_reg        <= db_cnt_next;
      long_cnt_reg      <= long_cnt_next;
      ret_long_reg      <= ret_long_next;
      pressed_reg       <= pressed_next;
      long_held_reg     <= long_held_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
      long_pulse_reg    <= long_pulse_next;
    end
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign long_pulse    = long_pulse_reg;
  assign long_held     = long_held_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: directed button waveforms push expected
// pulse events; a negedge monitor pops and compares whenever a pulse appears.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic pressed, press_pulse, release_pulse, long_pulse, long_held;

  button_debounce #(
    .clk_f          (1000),
    .t_debounce_ms  (4),
    .t_long_ms      (20),
    .btn_active_low (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .long_held     (long_held)
  );

  always #5 clk = ~clk;

  // Edge counter: cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int   kind;
    int   at;
    logic pressed;
    logic long_held;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  base     = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int rel, input logic p, input logic lh);
    ev_t e;
    e.kind = kind;
    e.at = base + rel;
    e.pressed = p;
    e.long_held = lh;
    exp_q.push_back(e);
  endtask

  task automatic mon_pop(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse kind=%0d cycle=%0d expected=none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d cycle=%0d (rel %0d) pressed=%0b long_held=%0b",
               kind, cyc, cyc - base, pressed, long_held);
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.at);
      chk("pulse_pressed", {31'd0, pressed}, {31'd0, e.pressed});
      chk("pulse_long_held", {31'd0, long_held}, {31'd0, e.long_held});
    end
  endtask

  always @(negedge clk) begin
    chk("single_pulse", {31'd0, ($countones({press_pulse, release_pulse, long_pulse}) <= 1)}, 32'd1);
    if (press_pulse)   mon_pop(K_PRESS);
    if (long_pulse)    mon_pop(K_LONG);
    if (release_pulse) mon_pop(K_RELEASE);
  end

  function automatic logic [31:0] outs();
    return {27'd0, pressed, press_pulse, release_pulse, long_pulse, long_held};
  endfunction

  task automatic step_to(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_scn();
    @(posedge clk);
    #1;
    base = cyc;
  endtask

  initial begin
    // Reset held for 3 cycles, then 50 idle cycles.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", outs(), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("idle_outs", outs(), 32'd0);
    end

    // Clean press and release.
    start_scn();
    expect_ev(K_PRESS, 16, 1'b1, 1'b0);
    expect_ev(K_RELEASE, 36, 1'b0, 1'b0);
    step_to(10); button = 1'b1;
    step_to(20); chk("clean_pressed_level", {31'd0, pressed}, 32'd1);
    step_to(30); button = 1'b0;
    step_to(45); chk("clean_released_level", {31'd0, pressed}, 32'd0);

    // Press bounce: last rising edge at 14.
    start_scn();
    expect_ev(K_PRESS, 20, 1'b1, 1'b0);
    expect_ev(K_RELEASE, 36, 1'b0, 1'b0);
    step_to(10); button = 1'b1;
    step_to(11); button = 1'b0;
    step_to(12); button = 1'b1;
    step_to(13); button = 1'b0;
    step_to(14); button = 1'b1;
    step_to(30); button = 1'b0;
    step_to(45);

    // 3-cycle high glitch: nothing must happen.
    start_scn();
    step_to(10); button = 1'b1;
    step_to(13); button = 1'b0;
    step_to(25); chk("glitch_pressed_level", {31'd0, pressed}, 32'd0);
    step_to(35);

    // 3-cycle low glitch while held, then a real release.
    start_scn();
    expect_ev(K_PRESS, 16, 1'b1, 1'b0);
    expect_ev(K_RELEASE, 34, 1'b0, 1'b0);
    step_to(10); button = 1'b1;
    step_to(20); button = 1'b0;
    step_to(23); button = 1'b1;
    step_to(27); chk("relglitch_pressed_level", {31'd0, pressed}, 32'd1);
    step_to(28); button = 1'b0;
    step_to(45);

    // Long press.
    start_scn();
    expect_ev(K_PRESS, 16, 1'b1, 1'b0);
    expect_ev(K_LONG, 36, 1'b1, 1'b1);
    expect_ev(K_RELEASE, 56, 1'b0, 1'b0);
    step_to(10); button = 1'b1;
    step_to(35); chk("long_held_before", {31'd0, long_held}, 32'd0);
    step_to(40); chk("long_held_level", {31'd0, long_held}, 32'd1);
    step_to(50); button = 1'b0;
    step_to(65); chk("long_held_after", {31'd0, long_held}, 32'd0);

    // Reset in HELD at long_cnt=10, button kept pressed.
    start_scn();
    expect_ev(K_PRESS, 16, 1'b1, 1'b0);
    step_to(10); button = 1'b1;
    step_to(26); rst_n = 1'b0;
    #1 chk("rst_mid_outs", outs(), 32'd0);
    step_to(28); chk("rst_mid_outs_hold", outs(), 32'd0);
    rst_n = 1'b1;
    expect_ev(K_PRESS, 34, 1'b1, 1'b0);
    expect_ev(K_LONG, 54, 1'b1, 1'b1);
    expect_ev(K_RELEASE, 66, 1'b0, 1'b0);
    step_to(60); button = 1'b0;
    step_to(80);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
